// File: rtl/lector_contadores.sv
// rtl/lector_contadores.sv - counter read-out requester: sweeps idx 0..3, captures counts and their sum
//
// Ports:
//   clk            : clock, all logic on posedge
//   reset          : asynchronous active-low reset
//   start          : 1-cycle pulse, begins a read sweep (ignored while busy)
//   IDLE           : design idle; a req is only issued while high
//   valid_contador : response qualifier from the counter block
//   contador_out   : returned count for the last requested idx
//   req            : 1-cycle read request
//   idx            : counter index being requested
//   busy           : sweep in progress
//   done           : 1-cycle pulse when the sweep completes
//   error_timeout  : sticky flag, some idx got no response in TIMEOUT cycles
//   cnt0..cnt3     : captured counts for idx 0..3
//   total          : cnt0+cnt1+cnt2+cnt3, two extra bits so it never wraps
module lector_contadores #(
  parameter int CNT_WIDTH = 5,
  parameter int IDX_WIDTH = 2,
  parameter int TIMEOUT   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 IDLE,
  input  logic                 valid_contador,
  input  logic [CNT_WIDTH-1:0] contador_out,
  output logic                 req,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 busy,
  output logic                 done,
  output logic                 error_timeout,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1,
  output logic [CNT_WIDTH-1:0] cnt2,
  output logic [CNT_WIDTH-1:0] cnt3,
  output logic [CNT_WIDTH+1:0] total
);

  localparam int NCNT = 2 ** IDX_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [7:0]           tcnt;
  logic [CNT_WIDTH-1:0] cnt_q [NCNT];

  logic take_start;
  logic capture;
  logic timeout_hit;
  logic last_idx;

  assign last_idx = (idx == IDX_WIDTH'(NCNT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // S_WAIT is only entered the cycle after req, so a valid that happens to be
  // high during the req cycle (pop activity) is never looked at.
  always_comb begin
    state_next  = state;
    req         = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    take_start  = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          take_start = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (IDLE) begin
          req        = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (valid_contador) begin
          capture    = 1'b1;
          state_next = S_NEXT;
        end else if (tcnt == 8'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = S_NEXT;
        end
      end
      S_NEXT: begin
        state_next = last_idx ? S_DONE : S_REQ;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx           <= '0;
      tcnt          <= '0;
      error_timeout <= 1'b0;
      total         <= '0;
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
    end else begin
      if (take_start) begin
        idx           <= '0;
        error_timeout <= 1'b0;
      end
      if (state == S_WAIT) begin
        if (capture) begin
          cnt_q[idx] <= contador_out;
        end else if (timeout_hit) begin
          cnt_q[idx]    <= '0;
          error_timeout <= 1'b1;
        end else begin
          tcnt <= tcnt + 8'd1;
        end
      end
      if (state == S_NEXT) begin
        tcnt <= '0;
        if (last_idx) begin
          total <= (CNT_WIDTH+2)'(cnt_q[0]) + (CNT_WIDTH+2)'(cnt_q[1])
                 + (CNT_WIDTH+2)'(cnt_q[2]) + (CNT_WIDTH+2)'(cnt_q[3]);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_lector_contadores.sv
// tb/tb_lector_contadores.sv - self-checking bench for lector_contadores
module tb_lector_contadores;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       IDLE;
  logic       valid_contador;
  logic [4:0] contador_out;
  logic       req;
  logic [1:0] idx;
  logic       busy;
  logic       done;
  logic       error_timeout;
  logic [4:0] cnt0, cnt1, cnt2, cnt3;
  logic [6:0] total;

  int total_cmp = 0;
  int bad = 0;

  int         exp_idx_q [$];
  logic [4:0] exp_cnt_q [$];

  localparam logic [4:0] JUNK = 5'h1E;

  lector_contadores #(.CNT_WIDTH(5), .IDX_WIDTH(2), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .IDLE(IDLE),
    .valid_contador(valid_contador), .contador_out(contador_out),
    .req(req), .idx(idx), .busy(busy), .done(done),
    .error_timeout(error_timeout),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .total(total)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; IDLE = 1'b1; valid_contador = 1'b0; contador_out = '0;
    repeat (2) @(negedge clk);
    #1;
    total_cmp++;
    if ({req, idx, busy, done, error_timeout} !== 6'd0) begin
      bad++; $display("FAIL reset_ctrl got req=%b idx=%0d busy=%b done=%b err=%b want all 0",
                      req, idx, busy, done, error_timeout);
    end
    total_cmp++;
    if ({cnt0, cnt1, cnt2, cnt3, total} !== 27'd0) begin
      bad++; $display("FAIL reset_data got cnt=%0d,%0d,%0d,%0d total=%0d want 0",
                      cnt0, cnt1, cnt2, cnt3, total);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Drives one sweep cycle by cycle. The responder answers one cycle after each
  // req (except for silent_idx); with hold_valid, valid stays high throughout
  // and contador_out carries junk in every cycle that is not a real response.
  task automatic run_sweep(input string name,
                           input logic [4:0] c0, input logic [4:0] c1,
                           input logic [4:0] c2, input logic [4:0] c3,
                           input int silent_idx, input int stall_idx, input int stall_len,
                           input bit hold_valid, input bit busy_start);
    logic [4:0] cv [4];
    logic [4:0] obs [4];
    logic [6:0] exp_total;
    logic       exp_err;
    int         exp_done;
    int         n_req, last_req, pidx, e;
    bit         pending, got_done, stall;
    cv = '{c0, c1, c2, c3};
    exp_idx_q.delete();
    exp_cnt_q.delete();
    exp_total = '0;
    exp_err   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_idx_q.push_back(i);
      if (i == silent_idx) begin
        exp_cnt_q.push_back(5'd0);
        exp_err = 1'b1;
      end else begin
        exp_cnt_q.push_back(cv[i]);
        exp_total = exp_total + 7'(cv[i]);
      end
    end
    exp_done = 13 + stall_len + ((silent_idx >= 0) ? 7 : 0);

    @(negedge clk);
    start = 1'b1; IDLE = 1'b1; valid_contador = hold_valid; contador_out = JUNK;
    n_req = 0; last_req = -100; pending = 1'b0; pidx = 0; got_done = 1'b0;
    for (int cyc = 1; cyc <= 200 && !got_done; cyc++) begin
      @(negedge clk);
      start = busy_start && (cyc == 5);
      stall = (n_req == stall_idx) && (cyc >= last_req + 3) && (cyc < last_req + 3 + stall_len);
      IDLE = !stall;
      contador_out   = pending ? cv[pidx] : JUNK;
      valid_contador = hold_valid || (pending && pidx != silent_idx);
      pending = 1'b0;
      #1;
      if (cyc == 1) begin
        total_cmp++;
        if (busy !== 1'b1 || error_timeout !== 1'b0) begin
          bad++; $display("FAIL %s_start got busy=%b err=%b want busy=1 err=0", name, busy, error_timeout);
        end
      end
      if (stall) begin
        total_cmp++;
        if (req !== 1'b0) begin
          bad++; $display("FAIL %s_stall_req cyc=%0d got req=%b want 0", name, cyc, req);
        end
      end
      if (req === 1'b1) begin
        total_cmp++;
        if (exp_idx_q.size() == 0) begin
          bad++; $display("FAIL %s_extra_req got idx=%0d want no req", name, idx);
        end else begin
          e = exp_idx_q.pop_front();
          if (idx !== 2'(e)) begin
            bad++; $display("FAIL %s_req_idx got %0d want %0d", name, idx, e);
          end
          pidx = e;
        end
        pending = 1'b1; n_req++; last_req = cyc;
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        total_cmp++;
        if (cyc != exp_done) begin
          bad++; $display("FAIL %s_done_cycle got %0d want %0d", name, cyc, exp_done);
        end
        obs = '{cnt0, cnt1, cnt2, cnt3};
        for (int i = 0; i < 4; i++) begin
          total_cmp++;
          if (exp_cnt_q.size() == 0) begin
            bad++; $display("FAIL %s_cnt%0d got %0d want queued value", name, i, obs[i]);
          end else begin
            e = int'(exp_cnt_q.pop_front());
            if (obs[i] !== 5'(e)) begin
              bad++; $display("FAIL %s_cnt%0d got %0d want %0d", name, i, obs[i], e);
            end
          end
        end
        total_cmp++;
        if (total !== exp_total) begin
          bad++; $display("FAIL %s_total got %0d want %0d", name, total, exp_total);
        end
        total_cmp++;
        if (error_timeout !== exp_err) begin
          bad++; $display("FAIL %s_err got %b want %b", name, error_timeout, exp_err);
        end
        total_cmp++;
        if (exp_idx_q.size() != 0) begin
          bad++; $display("FAIL %s_missing_req got %0d left want 0", name, exp_idx_q.size());
        end
      end
    end
    total_cmp++;
    if (!got_done) begin
      bad++; $display("FAIL %s_done_timeout got no done want done within 200 cycles", name);
    end
    start = 1'b0; valid_contador = 1'b0; IDLE = 1'b1; contador_out = JUNK;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      total_cmp++;
      if (busy !== 1'b0 || req !== 1'b0 || idx !== 2'd3) begin
        bad++; $display("FAIL %s_after_done got busy=%b req=%b idx=%0d want 0,0,3", name, busy, req, idx);
      end
    end
  endtask

  task automatic test_basic();
    run_sweep("basic", 5'd3, 5'd0, 5'd31, 5'd7, -1, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_sweep();
    bit pending, seen2;
    pending = 1'b0; seen2 = 1'b0;
    @(negedge clk);
    start = 1'b1; IDLE = 1'b1; valid_contador = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen2; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      valid_contador = pending;
      contador_out   = pending ? 5'd9 : JUNK;
      pending = 1'b0;
      #1;
      if (req === 1'b1) begin
        pending = 1'b1;
        if (idx === 2'd2) seen2 = 1'b1;
      end
    end
    total_cmp++;
    if (!seen2) begin
      bad++; $display("FAIL midreset_reach got no req idx=2 want req idx=2");
    end
    @(negedge clk);
    valid_contador = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    total_cmp++;
    if ({req, idx, busy, done, error_timeout} !== 6'd0) begin
      bad++; $display("FAIL midreset_ctrl got req=%b idx=%0d busy=%b done=%b err=%b want all 0",
                      req, idx, busy, done, error_timeout);
    end
    total_cmp++;
    if ({cnt0, cnt1, cnt2, cnt3, total} !== 27'd0) begin
      bad++; $display("FAIL midreset_data got cnt=%0d,%0d,%0d,%0d total=%0d want 0",
                      cnt0, cnt1, cnt2, cnt3, total);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total_cmp++;
    if (busy !== 1'b0 || req !== 1'b0) begin
      bad++; $display("FAIL midreset_no_resume got busy=%b req=%b want 0,0", busy, req);
    end
  endtask

  task automatic test_stall();
    run_sweep("stall", 5'd5, 5'd6, 5'd7, 5'd8, -1, 1, 5, 1'b0, 1'b0);
  endtask

  task automatic test_valid_held();
    run_sweep("vhold", 5'd12, 5'd1, 5'd20, 5'd2, -1, -1, 0, 1'b1, 1'b1);
  endtask

  task automatic test_no_wrap();
    run_sweep("max", 5'd31, 5'd31, 5'd31, 5'd31, -1, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_sweep("tmo", 5'd4, 5'd10, 5'd17, 5'd11, 2, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_sweep("ones", 5'd1, 5'd1, 5'd1, 5'd1, -1, -1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_sweep();
    test_stall();
    test_valid_held();
    test_no_wrap();
    test_timeout();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total_cmp, bad);
    $finish;
  end

endmodule
